// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and constants for the load/store memory stage.
package lsu_mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // True when the access size cannot be served at this byte offset.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size_e'(size))
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module load_extend
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_b = word[7:0];
    case (off)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = off[1] ? word[31:16] : word[15:0];

    result = word;
    case (size_e'(size))
      SZ_BYTE: result = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: result = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: turns the ALU address into a req/ack memory access, stalls the core
// while it is outstanding, and reports illegal accesses and memory timeouts as a fault.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [3:0]  mbe,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          fault_q;
  logic          load_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;

  logic          request, illegal, accept, timeout_hit;
  logic [3:0]    be;
  logic [31:0]   lane_wdata;
  logic [31:0]   ext_word;

  assign request = mem_rd | mem_wr;
  assign illegal = (mem_rd & mem_wr) | (size == SZ_RSVD) | is_misaligned(size, addr[1:0]);
  assign cnt_nxt = cnt + 1'b1;

  // Store lane steering: narrow data is replicated so the memory can pick any lane via mbe.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    case (size_e'(size))
      SZ_BYTE: begin
        be         = 4'b0001 << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    fault       = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request) begin
          if (illegal) begin
            fault = 1'b1;
          end else begin
            stall     = 1'b1;
            accept    = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mack) begin
          state_nxt = ST_DONE;
        end else if (cnt_nxt == CW'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: begin
        fault     = fault_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .word   (mrdata),
    .off    (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (ext_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      fault_q <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      rdata   <= '0;
      mreq    <= 1'b0;
      mwe     <= 1'b0;
      maddr   <= '0;
      mbe     <= '0;
      mwdata  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mreq    <= 1'b1;
        mwe     <= mem_wr;
        maddr   <= {addr[31:2], 2'b00};
        mbe     <= be;
        mwdata  <= lane_wdata;
        load_q  <= mem_rd;
        uns_q   <= uns;
        size_q  <= size;
        off_q   <= addr[1:0];
        cnt     <= '0;
        fault_q <= 1'b0;
      end else if (state == ST_WAIT) begin
        if (mack) begin
          mreq <= 1'b0;
          if (load_q) rdata <= ext_word;
        end else if (timeout_hit) begin
          mreq    <= 1'b0;
          fault_q <= 1'b1;
          rdata   <= '0;
        end else begin
          cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench: transaction-level memory/extension model plus directed and random accesses.
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic [31:0] addr, wdata, mrdata;
  logic        mem_rd, mem_wr, uns, mack;
  logic [1:0]  size;
  logic [31:0] rdata, maddr, mwdata;
  logic        stall, fault, mreq, mwe;
  logic [3:0]  mbe;

  lsu_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .size(size), .uns(uns), .rdata(rdata), .stall(stall),
    .fault(fault), .mreq(mreq), .mwe(mwe), .maddr(maddr), .mbe(mbe),
    .mwdata(mwdata), .mrdata(mrdata), .mack(mack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_model [64];
  logic [31:0] exp_rdata;
  logic [31:0] got_rdata, got_mwdata;
  logic [3:0]  got_mbe;
  logic        got_fault;
  int          got_stall_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_extend(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] sz, input logic un);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    if (sz == 2'b00) return un ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
    if (sz == 2'b01) return un ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return w;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'b0001 << off;
    if (sz == 2'b01) return 4'b0011 << {off[1], 1'b0};
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {4{wd[7:0]}};
    if (sz == 2'b01) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic model_illegal(input logic rd, input logic wr, input logic [1:0] sz,
                                         input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // One core request; ack_after = WAIT cycle carrying mack (0 or >TO means never).
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_after);
    int   widx;
    logic acked;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    widx  = int'(a[7:2]);
    acked = 1'b0;
    ebe   = model_be(sz, a[1:0]);
    ewd   = model_wdata(sz, wd);

    @(posedge clk); #1;
    addr = a; wdata = wd; mem_rd = rd; mem_wr = wr; size = sz; uns = un;
    mack = 1'($urandom_range(0, 1)); mrdata = $urandom;
    @(negedge clk);
    if (model_illegal(rd, wr, sz, a)) begin
      check("illegal_fault", 32'(fault), 32'd1);
      check("illegal_stall", 32'(stall), 32'd0);
      check("illegal_mreq",  32'(mreq),  32'd0);
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0; mack = 1'b0;
      @(negedge clk);
      check("illegal_after_mreq",  32'(mreq),  32'd0);
      check("illegal_after_fault", 32'(fault), 32'd0);
      got_fault = 1'b1;
      return;
    end
    check("req_stall", 32'(stall), 32'd1);
    check("req_fault", 32'(fault), 32'd0);
    check("req_mreq",  32'(mreq),  32'd0);
    got_stall_cycles = 1;

    for (int w = 1; w <= TO; w++) begin
      @(posedge clk); #1;
      mack   = (w == ack_after);
      mrdata = mack ? mem_model[widx] : $urandom;
      @(negedge clk);
      check("wait_mreq",  32'(mreq),  32'd1);
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_fault", 32'(fault), 32'd0);
      check("wait_mwe",   32'(mwe),   32'(wr));
      check("wait_maddr", maddr, {a[31:2], 2'b00});
      check("wait_mbe",   32'(mbe),   32'(ebe));
      if (wr) check("wait_mwdata", mwdata, ewd);
      got_stall_cycles += int'(stall);
      got_mbe    = mbe;
      got_mwdata = mwdata;
      if (mack) begin
        acked = 1'b1;
        break;
      end
    end

    // DONE: the core keeps presenting the request; stray mack must be ignored.
    @(posedge clk); #1;
    mack = 1'($urandom_range(0, 1)); mrdata = $urandom;
    if (acked) begin
      if (rd) exp_rdata = model_extend(mem_model[widx], a[1:0], sz, un);
      else
        for (int b = 0; b < 4; b++)
          if (ebe[b]) mem_model[widx][8*b +: 8] = ewd[8*b +: 8];
    end else begin
      exp_rdata = 32'h0;
    end
    @(negedge clk);
    check("done_mreq",  32'(mreq),  32'd0);
    check("done_stall", 32'(stall), 32'd0);
    check("done_fault", 32'(fault), 32'(!acked));
    check("done_rdata", rdata, exp_rdata);
    got_rdata = rdata;
    got_fault = fault;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    mack = 1'($urandom_range(0, 1)); mrdata = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_mreq",  32'(mreq),  32'd0);
    check("idle_fault", 32'(fault), 32'd0);
    check("idle_rdata", rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        rd, wr;
    int          r;

    rst_n = 1'b0; addr = '0; wdata = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    size = 2'b00; uns = 1'b0; mack = 1'b0; mrdata = '0;
    exp_rdata = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;

    #12;
    check("rst_rdata",  rdata,  32'h0);
    check("rst_stall",  32'(stall), 32'd0);
    check("rst_fault",  32'(fault), 32'd0);
    check("rst_mreq",   32'(mreq),  32'd0);
    check("rst_mwe",    32'(mwe),   32'd0);
    check("rst_maddr",  maddr,  32'h0);
    check("rst_mbe",    32'(mbe),   32'd0);
    check("rst_mwdata", mwdata, 32'h0);
    #5 rst_n = 1'b1;

    // Word store then load of the same address.
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 2);
    check("lit_st_mbe", 32'(got_mbe), 32'h0000000F);
    check("lit_st_stall_cycles", 32'(got_stall_cycles), 32'd3);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1);
    check("lit_ld_word", got_rdata, 32'hDEADBEEF);

    // Byte loads from lane 3.
    mem_model[0] = 32'h80FF1234;
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1);
    check("lit_lb", got_rdata, 32'hFFFFFF80);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 3);
    check("lit_lbu", got_rdata, 32'h00000080);

    // Half store to the upper half.
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 1);
    check("lit_sh_mbe",    32'(got_mbe), 32'h0000000C);
    check("lit_sh_mwdata", got_mwdata, 32'hABCDABCD);

    // Illegal accesses.
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1);
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 1);
    idle_cycle();

    // Timeout with no mack at all.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0);
    check("lit_to_rdata", got_rdata, 32'h0);
    check("lit_to_fault", 32'(got_fault), 32'd1);
    idle_cycle();

    // Re-load a nonzero value so the reset clearing rdata is visible.
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1);

    // Reset during WAIT, then a late mack after release.
    @(posedge clk); #1;
    addr = 32'h40; mem_rd = 1'b1; mem_wr = 1'b0; size = 2'b10; mack = 1'b0;
    @(negedge clk);
    check("rw_req_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_wait_mreq", 32'(mreq), 32'd1);
    #1 rst_n = 1'b0; mem_rd = 1'b0;
    #1;
    exp_rdata = 32'h0;
    check("rw_async_mreq",  32'(mreq),  32'd0);
    check("rw_async_stall", 32'(stall), 32'd0);
    check("rw_async_rdata", rdata, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 mack = 1'b1; mrdata = 32'h12345678;
    @(negedge clk);
    check("rw_late_stall", 32'(stall), 32'd0);
    check("rw_late_mreq",  32'(mreq),  32'd0);
    @(posedge clk); #1 mack = 1'b0;
    @(negedge clk);
    check("rw_late_rdata", rdata, 32'h0);
    check("rw_late_mreq2", 32'(mreq), 32'd0);

    // Randomized accesses, back-to-back or with idle gaps.
    for (int n = 0; n < 300; n++) begin
      r  = int'($urandom_range(0, 15));
      rd = (r <= 7);
      wr = (r == 0) || (r >= 8);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'h1000 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      wd = $urandom;
      access(rd, wr, sz, 1'($urandom_range(0, 1)), a, wd, int'($urandom_range(1, TO + 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
